// File: rtl/queue_calc_ctrl.sv
// Token-driven calculator front end for an external slot queue: operands are pushed,
// operators consume the front pair and push the result back, emit pops the front.
module queue_calc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        tok_valid,
  input  logic        tok_is_op,
  input  logic [7:0]  tok_data,
  output logic        tok_ready,
  output logic [7:0]  q_back,
  output logic [2:0]  q_pos_back,
  output logic [1:0]  q_opcode,
  input  logic [15:0] q_top_conc,
  output logic [7:0]  res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  q_count,
  output logic        busy,
  output logic        err_ovf,
  output logic        err_unf
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAIR,
    PAIR_WAIT,
    POP,
    POP_WAIT,
    EMIT
  } state_t;

  localparam logic [1:0] OPC_PUSH = 2'b00;
  localparam logic [1:0] OPC_PAIR = 2'b10;
  localparam logic [1:0] OPC_POP  = 2'b11;
  localparam logic [2:0] POS_NONE = 3'd7;
  localparam logic [2:0] DEPTH    = 3'd5;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [2:0]  count_q;
  logic [7:0]  alu_d;
  logic [7:0]  opnd_a;
  logic [7:0]  opnd_b;

  assign opnd_a = q_top_conc[15:8];
  assign opnd_b = q_top_conc[7:0];

  // 8-bit operators give the modulo-256 result directly.
  always_comb begin
    alu_d = opnd_a * opnd_b;
    case (op_q)
      2'b00:   alu_d = opnd_a + opnd_b;
      2'b01:   alu_d = opnd_a - opnd_b;
      default: alu_d = opnd_a * opnd_b;
    endcase
  end

  assign tok_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign q_count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      count_q    <= 3'd0;
      q_opcode   <= OPC_PUSH;
      q_pos_back <= POS_NONE;
      q_back     <= 8'd0;
      res_data   <= 8'd0;
      res_valid  <= 1'b0;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
    end else begin
      // Idle command unless a state below issues a real one this edge.
      q_opcode   <= OPC_PUSH;
      q_pos_back <= POS_NONE;
      q_back     <= 8'd0;

      case (state_q)
        IDLE: begin
          if (tok_valid) begin
            if (!tok_is_op) begin
              if (count_q < DEPTH) begin
                q_pos_back <= count_q;
                q_back     <= tok_data;
                count_q    <= count_q + 3'd1;
                state_q    <= CMD;
              end else begin
                err_ovf <= 1'b1;
              end
            end else if (tok_data[1:0] == 2'b11) begin
              if (count_q >= 3'd1) begin
                q_opcode <= OPC_POP;
                count_q  <= count_q - 3'd1;
                state_q  <= POP;
              end else begin
                err_unf <= 1'b1;
              end
            end else begin
              if (count_q >= 3'd2) begin
                op_q     <= tok_data[1:0];
                q_opcode <= OPC_PAIR;
                count_q  <= count_q - 3'd2;
                state_q  <= PAIR;
              end else begin
                err_unf <= 1'b1;
              end
            end
          end
        end
        CMD:       state_q <= IDLE;
        PAIR:      state_q <= PAIR_WAIT;
        PAIR_WAIT: begin
          q_pos_back <= count_q;
          q_back     <= alu_d;
          count_q    <= count_q + 3'd1;
          state_q    <= CMD;
        end
        POP:       state_q <= POP_WAIT;
        POP_WAIT: begin
          res_data  <= opnd_a;
          res_valid <= 1'b1;
          state_q   <= EMIT;
        end
        EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default:   state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_calc_ctrl.sv
// Directed bench for queue_calc_ctrl: behavioural slot queue, reference FIFO model
// and a result scoreboard checked at each result handshake.
module tb_queue_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tok_valid;
  logic        tok_is_op;
  logic [7:0]  tok_data;
  logic        tok_ready;
  logic [7:0]  q_back;
  logic [2:0]  q_pos_back;
  logic [1:0]  q_opcode;
  logic [15:0] q_top_conc;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  q_count;
  logic        busy;
  logic        err_ovf;
  logic        err_unf;

  int n_assert = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_op10   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sb[$];
  logic       exp_ovf;
  logic       exp_unf;

  always #5 clk = ~clk;

  queue_calc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tok_valid  (tok_valid),
    .tok_is_op  (tok_is_op),
    .tok_data   (tok_data),
    .tok_ready  (tok_ready),
    .q_back     (q_back),
    .q_pos_back (q_pos_back),
    .q_opcode   (q_opcode),
    .q_top_conc (q_top_conc),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .q_count    (q_count),
    .busy       (busy),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf)
  );

  // Behavioural 5-slot queue: front pair registered every edge, then the command applies.
  logic [7:0] mem [5];
  always @(posedge clk) begin
    if (rst) begin
      q_top_conc <= 16'd0;
      for (int i = 0; i < 5; i++) mem[i] <= 8'd0;
    end else begin
      q_top_conc <= {mem[0], mem[1]};
      case (q_opcode)
        2'b00: if (q_pos_back < 3'd5) mem[q_pos_back] <= q_back;
        2'b10: for (int i = 0; i < 5; i++) mem[i] <= (i + 2 < 5) ? mem[i + 2] : 8'd0;
        2'b11: for (int i = 0; i < 5; i++) mem[i] <= (i + 1 < 5) ? mem[i + 1] : 8'd0;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Command monitor and result scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (q_opcode == 2'b10) n_op10++;
      if (q_opcode == 2'b00 && q_pos_back != 3'd7) n_push++;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", {8'd0, res_data}, 16'hFFFF);
        end else begin
          check("result", {8'd0, res_data}, {8'd0, sb.pop_front()});
          $display("result 0x%02h consumed", res_data);
        end
      end
    end
  end

  task automatic send(input logic is_op, input logic [7:0] d);
    logic       got;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    got       = 1'b0;
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (tok_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    if (!got) check("tok_accept_timeout", 16'd0, 16'd1);
    $display("token is_op=%0d data=0x%02h accepted=%0d", is_op, d, got);
    if (!is_op) begin
      if (exp_q.size() < 5) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end else if (d[1:0] == 2'b11) begin
      if (exp_q.size() >= 1) sb.push_back(exp_q.pop_front());
      else exp_unf = 1'b1;
    end else if (exp_q.size() >= 2) begin
      a = exp_q.pop_front();
      b = exp_q.pop_front();
      case (d[1:0])
        2'b00:   r = a + b;
        2'b01:   r = a - b;
        default: r = a * b;
      endcase
      exp_q.push_back(r);
    end else begin
      exp_unf = 1'b1;
    end
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 16'd0, 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic is_op, input logic [7:0] d);
    send(is_op, d);
    wait_idle();
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_count"}, {13'd0, q_count}, 16'(exp_q.size()));
    check({tag, "_ovf"}, {15'd0, err_ovf}, {15'd0, exp_ovf});
    check({tag, "_unf"}, {15'd0, err_unf}, {15'd0, exp_unf});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    sb.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_tok_ready"}, {15'd0, tok_ready}, 16'd1);
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_count"}, {13'd0, q_count}, 16'd0);
    check({tag, "_idle_cmd"}, {3'd0, q_opcode, q_pos_back, q_back}, {3'd0, 2'b00, 3'd7, 8'd0});
    check({tag, "_res"}, {7'd0, res_valid, res_data}, 16'd0);
    check({tag, "_flags"}, {14'd0, err_ovf, err_unf}, 16'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         p0;
    logic       seen;
    rst       = 1'b1;
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = 8'd0;
    res_ready = 1'b1;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    check_reset_state("reset");

    // Add: 3 + 5 = 8
    op(1'b0, 8'd3);
    op(1'b0, 8'd5);
    op(1'b1, 8'h00);
    check_status("add_pre_emit");
    op(1'b1, 8'h03);
    check_status("add_post_emit");

    // Wrap-around results
    op(1'b0, 8'd3);
    op(1'b0, 8'd5);
    op(1'b1, 8'h01);
    op(1'b1, 8'h03);
    op(1'b0, 8'd20);
    op(1'b0, 8'd13);
    op(1'b1, 8'h02);
    op(1'b1, 8'h03);
    check_status("wrap");

    // Overflow on sixth operand
    for (int i = 1; i <= 5; i++) op(1'b0, 8'(i));
    p0 = n_push;
    op(1'b0, 8'd6);
    repeat (2) @(posedge clk);
    #1;
    check("ovf_no_push", 16'(n_push - p0), 16'd0);
    check_status("ovf");
    for (int i = 0; i < 5; i++) op(1'b1, 8'h03);
    check_status("ovf_drained");

    // Underflow on operator with one operand
    op(1'b0, 8'd7);
    p0 = n_op10;
    op(1'b1, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("unf_no_pair", 16'(n_op10 - p0), 16'd0);
    check_status("unf");
    op(1'b1, 8'h03);
    op(1'b1, 8'h03);
    check_status("unf_empty_emit");

    // Backpressure on result
    op(1'b0, 8'h9A);
    res_ready = 1'b0;
    send(1'b1, 8'h03);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", {15'd0, seen}, 16'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_hold", {6'd0, res_valid, tok_ready, res_data}, {6'd0, 1'b1, 1'b0, 8'h9A});
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release", {14'd0, busy, res_valid}, 16'd0);
    check("bp_tok_ready", {15'd0, tok_ready}, 16'd1);
    @(posedge clk);
    #1;
    check_status("bp");

    // Reset while in PAIR_WAIT; flags are set at this point
    op(1'b0, 8'd1);
    op(1'b0, 8'd2);
    send(1'b1, 8'h00);
    @(posedge clk);
    #1;
    do_reset();
    check_reset_state("midop_reset");

    // Processing resumes after reset
    op(1'b0, 8'd10);
    op(1'b0, 8'd4);
    op(1'b1, 8'h01);
    op(1'b1, 8'h03);
    check_status("post_reset");
    check("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_calc_ctrl.md
QUEUE_CALC_CTRL -- requirements
Module: queue_calc_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 tok_valid  input  1  token offered.
REQ-004 tok_is_op  input  1  1 = operator token, 0 = operand token.
REQ-005 tok_data  input  8  operand value, or operator code in [1:0] (00 add, 01 sub, 10 mul, 11 emit).
REQ-006 tok_ready  output  1  token accepted on an edge where tok_valid and tok_ready are both 1.
REQ-007 q_back  output  8  data to queue push port (registered).
REQ-008 q_pos_back  output  3  queue push slot (registered).
REQ-009 q_opcode  output  2  queue command (registered): 00 push, 10 take pair, 11 pop front.
REQ-010 q_top_conc  input  16  queue front output, {first, second}.
REQ-011 res_data  output  8  emitted value.
REQ-012 res_valid  output  1  res_data valid; held until res_ready.
REQ-013 res_ready  input  1  consumer accepts res_data.
REQ-014 q_count  output  3  committed queue occupancy, 0..5.
REQ-015 busy  output  1  state != IDLE.
REQ-016 err_ovf / err_unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 Idle command SHALL be q_opcode=00, q_pos_back=7, q_back=0; slot 7 is a no-write slot, and every non-command cycle drives it.
REQ-018 States SHALL be IDLE, CMD, PAIR, PAIR_WAIT, POP, POP_WAIT, EMIT; tok_ready=1 only in IDLE.
REQ-019 Operand accepted, count<5: register push (opcode 00, pos=count, back=tok_data); count+1; go to CMD.
REQ-020 CMD: command present for exactly one cycle; next edge drives idle command and returns to IDLE.
REQ-021 Operand accepted, count=5: set err_ovf, token dropped, no queue command, stay IDLE.
REQ-022 Add/sub/mul accepted, count>=2: register opcode 10, pos 7; count-2; go to PAIR.
REQ-023 PAIR: next edge drives idle command and goes to PAIR_WAIT.
REQ-024 PAIR_WAIT: a=q_top_conc[15:8], b=q_top_conc[7:0]; result r = a+b, a-b or a*b.
REQ-025 Result width: r SHALL be truncated to 8 bits, modulo 256, with no flags.
REQ-026 PAIR_WAIT exit: register push (opcode 00, pos=count, back=r); count+1; go to CMD.
REQ-027 Operator latency: accept edge T; queue shifts at T+1; push registered at T+2; queue written at T+3; IDLE from T+3.
REQ-028 Add/sub/mul accepted, count<2: set err_unf, no queue command, count unchanged, stay IDLE.
REQ-029 Emit accepted, count>=1: register opcode 11, pos 7; count-1; go to POP.
REQ-030 POP: next edge drives idle command and goes to POP_WAIT.
REQ-031 POP_WAIT: register res_data=q_top_conc[15:8]; set res_valid=1; go to EMIT.
REQ-032 EMIT: res_data and res_valid SHALL be held stable until an edge with res_ready=1; that edge clears res_valid and returns to IDLE.
REQ-033 Emit accepted, count=0: set err_unf, no queue command, stay IDLE.
REQ-034 Error flags SHALL stay set until rst; processing continues after an error.
REQ-035 tok_valid while not IDLE SHALL be ignored; the source holds the token.

Reset
REQ-036 rst SHALL override everything, in any state, on the next edge.
REQ-037 On rst: state=IDLE, count=0, idle command driven, res_data=0, res_valid=0, err_ovf=0, err_unf=0; tok_ready=1 from the following cycle.
REQ-038 The queue shares rst; reset mid-operation SHALL leave no partial command pending.

Verification
REQ-039 Add: push 3, push 5, add, emit -> res_data=0x08, q_count 0 after emit, no error flags.
REQ-040 Wrap: push 3, push 5, sub -> emit 0xFE; push 20, push 13, mul -> emit 0x04.
REQ-041 Overflow: push 6 operands 1..6 -> err_ovf=1 after 6th, q_count=5, no push issued; 5 emits yield 1,2,3,4,5.
REQ-042 Underflow: push 7, add -> err_unf=1, q_count=1, no opcode 10 issued; emit -> 0x07.
REQ-043 Backpressure: emit with res_ready low 4 cycles -> res_valid=1 and res_data stable all 4 cycles, tok_ready=0; IDLE one edge after res_ready rises.
REQ-044 Reset mid-op: rst asserted in PAIR_WAIT -> next cycle state IDLE, q_count=0, res_valid=0, idle command driven, flags 0.
